maze_player_tracker: RTL and testbench
======================================

Name: maze_player_tracker

Overview:
- Sits directly downstream of the button handler and closes the position loop.
- Consumes the handler's proposed position next_count, registers the accepted position count, and feeds count back to the handler.
- Owns the game-progress FSM: start, lives, wall-hit penalty, respawn, win/lose, and the move counter.
- Drives game_pause back to the handler and provides status to the display logic.

Parameters:
- LIVES, 3, lives at game start (1..7).
- PENALTY_TICKS, 10, CLK cycles frozen after a wall hit (2 s at 5 Hz).
- MAZE_CELLS, 198, valid cell indices 0..MAZE_CELLS-1 (11 rows x 18 columns).
- WALL_CODE, 255, handler's wall-hit marker.
- RESET_SPOT, 181, count value during reset.
- MOVE_MAX, 999, move counter saturation value.

Ports:
- CLK  in  1  game tick clock, the same 5 Hz clock as the button handler.
- RST  in  1  asynchronous, active-high reset.
- next_count  in  8  proposed position from the handler.
- begin_spot  in  8  start cell.
- end_spot  in  8  goal cell.
- CTRLbtn  in  1  start/restart button, level, already debounced.
- count  out  8  accepted player position, fed back to the handler.
- game_pause  out  1  freezes the handler.
- lives_left  out  3  remaining lives.
- move_count  out  10  accepted moves, saturating.
- hit_flash  out  1  high during the penalty window.
- win  out  1  goal reached.
- lose  out  1  lives exhausted.

Behaviour:
Reset (async assert, sync release):
- state=IDLE, count=RESET_SPOT, game_pause=1, lives_left=LIVES, move_count=0, hit_flash=0, win=0, lose=0, penalty timer=0.

Validity:
- next_count is a wall if it equals WALL_CODE or is >= MAZE_CELLS.
- Otherwise it is a valid cell.

All transitions are on the CLK rising edge; outputs are registered, with 1-cycle latency from next_count.

IDLE:
- count<=begin_spot every cycle; game_pause=1.
- CTRLbtn=1 -> lives_left<=LIVES, move_count<=0, go to PLAY.

PLAY (game_pause=0):
- Wall -> lives_left<=lives_left-1, timer<=PENALTY_TICKS-1, count unchanged, go to PENALTY.
- Valid and next_count != count:
  - count<=next_count; move_count<=move_count+1, saturating at MOVE_MAX.
  - If next_count==end_spot, go to WIN in the same edge, with count updated.
- Valid and next_count==count: no change.

PENALTY (game_pause=1, hit_flash=1):
- Timer decrements each cycle.
- At timer==0: if lives_left==0 go to LOSE; else count<=begin_spot and go to ARMED.

ARMED (game_pause=0, count held at begin_spot):
- This state waits for the handler to leave WALL_CODE, either through CTRLbtn or a direction press.
- next_count valid -> go to PLAY and apply the PLAY accept rule in the same edge, including the move increment and the win check.
- Wall -> stay in ARMED; no life is lost.

WIN (win=1, game_pause=1) and LOSE (lose=1, game_pause=1):
- All values hold.
- CTRLbtn rising edge -> go to IDLE and clear win/lose.
- Rising edge is detected with a 1-bit registered copy of CTRLbtn. The entry press must not auto-restart, so a press held since PLAY is ignored until it is released.

Edge cases:
- If begin_spot==end_spot, the game does not win until the player moves off and back.
- lives_left never underflows: decrement happens only in PLAY, where lives_left >= 1.
- RST mid-game returns to IDLE immediately, asynchronously.

Decomposition:
- Shared package maze_pkg holds:
  - the state enum (IDLE, PLAY, PENALTY, ARMED, WIN, LOSE), 3-bit encoding;
  - WALL_CODE, MAZE_CELLS, MAZE_COLS=18;
  - a cell_t 8-bit typedef.
- One natural sub-module: tick_down_timer, a loadable down-counter with zero flag, used for PENALTY_TICKS.
- Everything else stays inline.

Test Plan:
- Reset then IDLE: RST pulse, begin_spot=19 -> count=181 during RST, count=19 one cycle after release; game_pause=1, lives_left=3.
- Normal walk: CTRLbtn, then next_count 19->20->38 -> count follows with 1-cycle lag, move_count=2, game_pause=0. Repeating 38 leaves move_count=2.
- Wall hit: next_count=255 in PLAY -> lives_left=2, game_pause=1 and hit_flash=1 for exactly 10 cycles. Then count=begin_spot in ARMED. Holding next_count=255 keeps ARMED with lives_left=2; next_count=19 enters PLAY.
- Out-of-range: next_count=200 -> treated as a wall, lives_left decrements.
- Lose: three wall hits -> after the third penalty, lose=1 and game_pause=1. CTRLbtn held through entry is ignored; release then press -> IDLE, lives_left=3.
- Win and saturation:
  - end_spot=40, next_count=40 -> win=1 the same cycle count=40; later next_count changes are ignored.
  - Separately, a forced 1000 alternating moves -> move_count stops at 999.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared types and constants for the maze game position/progress logic.
package maze_pkg;

   localparam int unsigned WALL_CODE  = 255;
   localparam int unsigned MAZE_CELLS = 198;
   localparam int unsigned MAZE_COLS  = 18;

   typedef logic [7:0] cell_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PLAY    = 3'd1,
      PENALTY = 3'd2,
      ARMED   = 3'd3,
      WIN     = 3'd4,
      LOSE    = 3'd5
   } state_t;

endpackage

// File: rtl/tick_down_timer.sv
// Loadable down-counter that stops at zero; zero_c flags the terminal count.
module tick_down_timer #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic             zero_c
);

   logic [WIDTH-1:0] value;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         value <= '0;
      else if (load)
         value <= load_val;
      else if (en && (value != '0))
         value <= value - WIDTH'(1);
   end

   assign zero_c = (value == '0);

endmodule

// File: rtl/maze_player_tracker.sv
// Accepts handler position proposals, tracks lives/moves, and runs the
// game-progress FSM (start, wall penalty, respawn, win/lose).
module maze_player_tracker
   import maze_pkg::*;
#(
   parameter int unsigned LIVES         = 3,
   parameter int unsigned PENALTY_TICKS = 10,
   parameter int unsigned MAZE_CELLS    = maze_pkg::MAZE_CELLS,
   parameter int unsigned WALL_CODE     = maze_pkg::WALL_CODE,
   parameter int unsigned RESET_SPOT    = 181,
   parameter int unsigned MOVE_MAX      = 999
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] next_count,
   input  logic [7:0] begin_spot,
   input  logic [7:0] end_spot,
   input  logic       CTRLbtn,
   output logic [7:0] count,
   output logic       game_pause,
   output logic [2:0] lives_left,
   output logic [9:0] move_count,
   output logic       hit_flash,
   output logic       win,
   output logic       lose
);

   localparam int unsigned TMR_W = (PENALTY_TICKS > 1) ? $clog2(PENALTY_TICKS) : 1;
   localparam cell_t       CELLS_C   = cell_t'(MAZE_CELLS);
   localparam cell_t       WALL_C    = cell_t'(WALL_CODE);
   localparam logic [9:0]  MOVE_MAX_C = 10'(MOVE_MAX);

   state_t     state, state_n;
   cell_t      count_n;
   logic [2:0] lives_n;
   logic [9:0] moves_n;
   logic       ctrl_q;
   logic       ctrl_rise_c;
   logic       wall_c;
   logic       accept_c;
   logic       tmr_load;
   logic       tmr_en;
   logic       tmr_zero_c;

   assign wall_c      = (next_count == WALL_C) || (next_count >= CELLS_C);
   assign accept_c    = !wall_c && (next_count != count);
   assign ctrl_rise_c = CTRLbtn && !ctrl_q;

   tick_down_timer #(.WIDTH(TMR_W)) u_penalty_timer (
      .CLK      (CLK),
      .RST      (RST),
      .load     (tmr_load),
      .load_val (TMR_W'(PENALTY_TICKS - 1)),
      .en       (tmr_en),
      .zero_c   (tmr_zero_c)
   );

   // State and all outputs registered from their next values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= IDLE;
         count      <= cell_t'(RESET_SPOT);
         game_pause <= 1'b1;
         lives_left <= 3'(LIVES);
         move_count <= '0;
         hit_flash  <= 1'b0;
         win        <= 1'b0;
         lose       <= 1'b0;
         ctrl_q     <= 1'b0;
      end else begin
         state      <= state_n;
         count      <= count_n;
         game_pause <= (state_n != PLAY) && (state_n != ARMED);
         lives_left <= lives_n;
         move_count <= moves_n;
         hit_flash  <= (state_n == PENALTY);
         win        <= (state_n == WIN);
         lose       <= (state_n == LOSE);
         ctrl_q     <= CTRLbtn;
      end
   end

   // Next-state and datapath updates.
   always_comb begin
      state_n  = state;
      count_n  = count;
      lives_n  = lives_left;
      moves_n  = move_count;
      tmr_load = 1'b0;
      tmr_en   = 1'b0;

      case (state)
         IDLE: begin
            count_n = begin_spot;
            if (CTRLbtn) begin
               lives_n = 3'(LIVES);
               moves_n = '0;
               state_n = PLAY;
            end
         end
         PLAY, ARMED: begin
            if (wall_c) begin
               if (state == PLAY) begin
                  lives_n  = lives_left - 3'd1;
                  tmr_load = 1'b1;
                  state_n  = PENALTY;
               end
            end else begin
               state_n = PLAY;
               if (accept_c) begin
                  count_n = next_count;
                  moves_n = (move_count >= MOVE_MAX_C) ? move_count : move_count + 10'd1;
                  if (next_count == end_spot)
                     state_n = WIN;
               end
            end
         end
         PENALTY: begin
            tmr_en = 1'b1;
            if (tmr_zero_c) begin
               if (lives_left == 3'd0) begin
                  state_n = LOSE;
               end else begin
                  count_n = begin_spot;
                  state_n = ARMED;
               end
            end
         end
         WIN, LOSE: begin
            // Restart restores the same scoreboard a reset would give.
            if (ctrl_rise_c) begin
               lives_n = 3'(LIVES);
               moves_n = '0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_maze_player_tracker.sv
// Directed bench for maze_player_tracker with hand-computed expectations.
module tb_maze_player_tracker;

   logic       CLK;
   logic       RST;
   logic [7:0] next_count;
   logic [7:0] begin_spot;
   logic [7:0] end_spot;
   logic       CTRLbtn;
   logic [7:0] count;
   logic       game_pause;
   logic [2:0] lives_left;
   logic [9:0] move_count;
   logic       hit_flash;
   logic       win;
   logic       lose;

   int n_checks;
   int n_errors;

   maze_player_tracker dut (
      .CLK        (CLK),
      .RST        (RST),
      .next_count (next_count),
      .begin_spot (begin_spot),
      .end_spot   (end_spot),
      .CTRLbtn    (CTRLbtn),
      .count      (count),
      .game_pause (game_pause),
      .lives_left (lives_left),
      .move_count (move_count),
      .hit_flash  (hit_flash),
      .win        (win),
      .lose       (lose)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Step through a penalty window; returns how many cycles hit_flash stayed high.
   task automatic ride_penalty(output int cycles);
      cycles = 0;
      for (int i = 0; i < 30 && hit_flash; i++) begin
         cycles++;
         step();
      end
   endtask

   int pen_cycles;

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      RST        = 1'b0;
      next_count = 8'd255;
      begin_spot = 8'd19;
      end_spot   = 8'd40;
      CTRLbtn    = 1'b0;
      #2 RST = 1'b1;
      step();
      step();
      check("rst_count", count, 181);
      check("rst_pause", game_pause, 1);
      check("rst_lives", lives_left, 3);
      check("rst_moves", move_count, 0);
      check("rst_winlose", {win, lose}, 0);
      RST = 1'b0;
      step();
      check("idle_count", count, 19);
      check("idle_pause", game_pause, 1);
      check("idle_lives", lives_left, 3);

      // Normal walk
      CTRLbtn    = 1'b1;
      next_count = 8'd19;
      step();
      CTRLbtn = 1'b0;
      check("play_pause", game_pause, 0);
      check("play_count0", count, 19);
      check("play_moves0", move_count, 0);
      next_count = 8'd20;
      step();
      check("walk_count1", count, 20);
      check("walk_moves1", move_count, 1);
      next_count = 8'd38;
      step();
      check("walk_count2", count, 38);
      check("walk_moves2", move_count, 2);
      step();
      check("walk_repeat_moves", move_count, 2);
      check("walk_repeat_pause", game_pause, 0);

      // Wall hit and penalty window
      next_count = 8'd255;
      step();
      check("wall_lives", lives_left, 2);
      check("wall_flash", hit_flash, 1);
      check("wall_pause", game_pause, 1);
      check("wall_count_held", count, 38);
      ride_penalty(pen_cycles);
      check("penalty_len", pen_cycles, 10);
      check("armed_count", count, 19);
      check("armed_pause", game_pause, 0);
      step();
      step();
      check("armed_wall_lives", lives_left, 2);
      check("armed_wall_flash", hit_flash, 0);
      check("armed_wall_count", count, 19);
      next_count = 8'd19;
      step();
      check("rearm_moves", move_count, 2);
      next_count = 8'd20;
      step();
      check("rearm_walk_count", count, 20);
      check("rearm_walk_moves", move_count, 3);

      // Out-of-range cell counts as a wall
      next_count = 8'd200;
      step();
      check("oor_lives", lives_left, 1);
      check("oor_flash", hit_flash, 1);
      ride_penalty(pen_cycles);
      check("oor_penalty_len", pen_cycles, 10);
      next_count = 8'd19;
      step();
      check("oor_resume_pause", game_pause, 0);

      // Last life lost; button held through entry must not restart
      next_count = 8'd255;
      step();
      check("last_lives", lives_left, 0);
      CTRLbtn = 1'b1;
      ride_penalty(pen_cycles);
      check("lose_flag", lose, 1);
      check("lose_pause", game_pause, 1);
      check("lose_count", count, 19);
      step();
      step();
      check("lose_held_btn", lose, 1);
      CTRLbtn = 1'b0;
      step();
      check("lose_released", lose, 1);
      CTRLbtn = 1'b1;
      step();
      CTRLbtn = 1'b0;
      check("restart_lose", lose, 0);
      check("restart_pause", game_pause, 1);
      check("restart_lives", lives_left, 3);
      step();
      check("restart_idle_count", count, 19);

      // Win
      CTRLbtn    = 1'b1;
      next_count = 8'd19;
      step();
      CTRLbtn = 1'b0;
      check("win_play_pause", game_pause, 0);
      next_count = 8'd40;
      step();
      check("win_flag", win, 1);
      check("win_count", count, 40);
      check("win_pause", game_pause, 1);
      check("win_moves", move_count, 1);
      next_count = 8'd41;
      step();
      check("win_hold_count", count, 40);
      check("win_hold_moves", move_count, 1);

      // Move counter saturation
      CTRLbtn = 1'b1;
      step();
      check("win_restart", win, 0);
      next_count = 8'd19;
      step();
      CTRLbtn = 1'b0;
      check("sat_start_moves", move_count, 0);
      for (int i = 0; i < 1000; i++) begin
         next_count = (i % 2 == 0) ? 8'd20 : 8'd21;
         step();
      end
      check("sat_moves", move_count, 999);
      check("sat_count", count, 21);
      next_count = 8'd20;
      step();
      check("sat_moves_hold", move_count, 999);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
